// File: rtl/integrador_pkg.sv
// Shared fixed-point definitions for the servo I_PD controller stages.
// Holds the word format (MAGNITUD integer bits, DECIMAL fractional bits,
// one sign bit), the full-scale limits of that word, and the
// fixed-point multiply helpers shared by the P, I and D stages.
package integrador_pkg;

  localparam int MAGNITUD = 17;
  localparam int DECIMAL  = 0;
  localparam int N        = MAGNITUD + DECIMAL + 1;

  localparam logic signed [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  // Full-width product realigned to the data Q format. The result is still
  // 2N bits wide, so the caller decides how to bring it back into range.
  function automatic logic signed [2*N-1:0] fx_mul(input logic signed [N-1:0] a,
                                                   input logic signed [N-1:0] b);
    logic signed [2*N-1:0] p;
    p = (2*N)'(a) * (2*N)'(b);
    return p >>> DECIMAL;
  endfunction

  // Multiply and clamp to the full N-bit range in one step. The result
  // never wraps, so an overflowing product keeps its sign.
  function automatic logic signed [N-1:0] fx_mul_sat(input logic signed [N-1:0] a,
                                                     input logic signed [N-1:0] b);
    logic signed [2*N-1:0] p;
    p = fx_mul(a, b);
    if (p > (2*N)'(MAX_POS))      return MAX_POS;
    else if (p < (2*N)'(MIN_NEG)) return MIN_NEG;
    else                          return p[N-1:0];
  endfunction

endpackage

// File: rtl/integrador_if.sv
// Sample/result bundle between the error subtractor, the integral stage
// and the control-sum adder.
//   enable     sample strobe, one-cycle pulse per control period
//   clear      synchronous accumulator clear
//   hold       freeze accumulation (anti-windup from the outer loop)
//   e          signed error sample
//   integrador signed KI*accumulator result
//   valid      one-cycle pulse when integrador reflects the latest sample
//   sat        accumulator sits at one of its limits
// master drives the sample side, slave is the integral stage.
interface integrador_if;
  import integrador_pkg::*;

  logic                enable;
  logic                clear;
  logic                hold;
  logic signed [N-1:0] e;
  logic signed [N-1:0] integrador;
  logic                valid;
  logic                sat;

  modport master (output enable, clear, hold, e,
                  input  integrador, valid, sat);
  modport slave  (input  enable, clear, hold, e,
                  output integrador, valid, sat);
endinterface

// File: rtl/integrador_saturador.sv
// saturador: signed clamp from IN_W bits down to OUT_W bits.
//   din      signed input, IN_W bits
//   lim_pos  upper bound (OUT_W bits, signed)
//   lim_neg  lower bound (OUT_W bits, signed)
//   dout     din clamped to [lim_neg, lim_pos]
// Both limits must be representable in OUT_W bits, which makes the
// in-range truncation of din lossless.
module saturador #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 18
) (
  input  logic signed [IN_W-1:0]  din,
  input  logic signed [OUT_W-1:0] lim_pos,
  input  logic signed [OUT_W-1:0] lim_neg,
  output logic signed [OUT_W-1:0] dout
);

  logic signed [IN_W-1:0] pos_w;
  logic signed [IN_W-1:0] neg_w;

  always_comb begin
    pos_w = IN_W'(lim_pos);
    neg_w = IN_W'(lim_neg);
    if (din > pos_w)      dout = lim_pos;
    else if (din < neg_w) dout = lim_neg;
    else                  dout = din[OUT_W-1:0];
  end

endmodule

// File: rtl/integrador.sv
// integrador: integral term of the servo I_PD controller.
// Accumulates the signed error once per sample strobe into a clamped
// (anti-windup) register, scales it by KI and presents the product after a
// two-register pipeline together with a valid pulse.
//   clk    system clock, rising edge
//   reset  synchronous, active-high; clears all state
//   bus    integrador_if.slave (enable, clear, hold, e -> integrador, valid, sat)
module integrador
  import integrador_pkg::*;
#(
  parameter logic signed [N-1:0] KI      = N'(3),
  parameter logic signed [N-1:0] ACC_LIM = MAX_POS
) (
  input  logic         clk,
  input  logic         reset,
  integrador_if.slave  bus
);

  localparam logic signed [N-1:0] ACC_NEG = -ACC_LIM;

  logic signed [N-1:0]   acc_r;
  logic signed [N-1:0]   prod_r;
  logic signed [N-1:0]   out_r;
  logic                  sat_r;
  logic [2:0]            vld_sr;   // enable travelling through acc, prod, out

  logic signed [N:0]     sum;
  logic signed [N-1:0]   acc_next;
  logic                  acc_hit;
  logic signed [2*N-1:0] prod_full;
  logic signed [N-1:0]   prod_next;

  // One extra bit keeps acc + e exact even for e = MIN_NEG.
  assign sum       = (N+1)'(acc_r) + (N+1)'(bus.e);
  assign acc_hit   = (acc_next == ACC_LIM) || (acc_next == ACC_NEG);
  assign prod_full = fx_mul(acc_r, KI);

  saturador #(.IN_W(N+1), .OUT_W(N)) u_sat_acc (
    .din     (sum),
    .lim_pos (ACC_LIM),
    .lim_neg (ACC_NEG),
    .dout    (acc_next)
  );

  saturador #(.IN_W(2*N), .OUT_W(N)) u_sat_prod (
    .din     (prod_full),
    .lim_pos (MAX_POS),
    .lim_neg (MIN_NEG),
    .dout    (prod_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r  <= '0;
      sat_r  <= 1'b0;
      prod_r <= '0;
      out_r  <= '0;
      vld_sr <= '0;
    end else begin
      if (bus.clear) begin
        acc_r <= '0;
        sat_r <= 1'b0;
      end else if (bus.enable && !bus.hold) begin
        acc_r <= acc_next;
        sat_r <= acc_hit;
      end
      // The product pipeline runs every cycle; valid only marks which
      // output corresponds to a sample (held or cleared samples included).
      prod_r <= prod_next;
      out_r  <= prod_r;
      vld_sr <= {vld_sr[1:0], bus.enable};
    end
  end

  assign bus.integrador = out_r;
  assign bus.valid      = vld_sr[2];
  assign bus.sat        = sat_r;

endmodule

// File: tb/tb_integrador.sv
// Testbench for integrador: table of sample records driven back to back,
// scoreboard queue of expected results popped on every valid pulse, plus
// hand-written sequences for latency and mid-pipeline reset.
module tb_integrador;

  logic clk = 1'b0;
  logic reset;

  integrador_if bus_if ();

  integrador dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic clr;
    logic hold;
    logic en;
    int   e;
    int   exp_out;
    logic exp_sat;
  } vec_t;

  vec_t vq[$];
  int   exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic add(input logic clr, input logic hold, input logic en,
                     input int e, input int exp_out, input logic exp_sat);
    vec_t v;
    v.clr = clr; v.hold = hold; v.en = en;
    v.e = e; v.exp_out = exp_out; v.exp_sat = exp_sat;
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic clr, input logic hold, input logic en, input int e);
    bus_if.clear  = clr;
    bus_if.hold   = hold;
    bus_if.enable = en;
    bus_if.e      = 18'(e);
  endtask

  // Scoreboard: every valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (bus_if.valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: got pulse with integrador=%0d expected no pulse",
                 int'(bus_if.integrador));
      end else begin
        check("scoreboard_out", int'(bus_if.integrador), exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // sample table: acc starts at 10 after the latency sequence
    add(1, 0, 0,      0,       0, 0);  // clear -> acc 0
    add(0, 0, 1,    100,     300, 0);
    add(0, 0, 1,    100,     600, 0);
    add(0, 0, 1,    100,     900, 0);
    add(0, 0, 1,    100,    1200, 0);
    add(0, 0, 1,    100,    1500, 0);  // acc 500
    add(1, 0, 1,     77,       0, 0);  // clear wins over enable
    add(0, 0, 1,    200,     600, 0);  // acc 200
    add(0, 1, 1,     50,     600, 0);  // held, still valid
    add(0, 0, 0,    999,       0, 0);  // idle, no pulse
    add(0, 0, 1, 130800,  131071, 0);  // acc 131000, product clamps
    add(0, 0, 1,    500,  131071, 1);  // acc clamps to 131071
    add(0, 0, 0,      0,       0, 1);  // idle keeps sat
    add(0, 0, 1,    -71,  131071, 0);  // acc 131000
    add(1, 0, 0,      0,       0, 0);
    add(0, 0, 1, -131072, -131072, 1); // acc -131071, product -> MIN_NEG
    add(0, 0, 1, -131072, -131072, 1); // still clamped, no sign flip
    add(0, 0, 1, 131071,       0, 0);  // acc 0
    add(0, 0, 1,     -5,     -15, 0);
    add(0, 1, 1,     -5,     -15, 0);  // held at -5
    add(1, 1, 1,      9,       0, 0);  // clear beats hold

    reset = 1'b1;
    drive(0, 0, 0, 0);
    repeat (3) step();
    check("reset_out",   int'(bus_if.integrador), 0);
    check("reset_valid", int'(bus_if.valid), 0);
    check("reset_sat",   int'(bus_if.sat), 0);

    // latency: single strobe, e=10 -> 30 two edges after acc updates
    reset = 1'b0;
    drive(0, 0, 1, 10);
    exp_q.push_back(30);
    step();
    drive(0, 0, 0, 0);
    check("lat_k_valid",  int'(bus_if.valid), 0);
    check("lat_k_out",    int'(bus_if.integrador), 0);
    step();
    check("lat_k1_valid", int'(bus_if.valid), 0);
    check("lat_k1_out",   int'(bus_if.integrador), 0);
    step();
    check("lat_k2_valid", int'(bus_if.valid), 1);
    check("lat_k2_out",   int'(bus_if.integrador), 30);
    step();
    check("lat_pulse_end", int'(bus_if.valid), 0);

    foreach (vq[i]) begin
      drive(vq[i].clr, vq[i].hold, vq[i].en, vq[i].e);
      if (vq[i].en) exp_q.push_back(vq[i].exp_out);
      step();
      check($sformatf("vec%0d_sat", i), int'(bus_if.sat), int'(vq[i].exp_sat));
    end
    drive(0, 0, 0, 0);
    repeat (4) step();
    check("table_drained", exp_q.size(), 0);

    // reset while a strobe is in flight: its pulse must never appear
    drive(0, 0, 1, 10);
    step();
    reset = 1'b1;
    drive(0, 0, 0, 0);
    step();
    check("midrst_out",   int'(bus_if.integrador), 0);
    check("midrst_valid", int'(bus_if.valid), 0);
    check("midrst_sat",   int'(bus_if.sat), 0);
    reset = 1'b0;
    step();
    check("midrst_valid_k2", int'(bus_if.valid), 0);
    step();
    check("midrst_valid_k3", int'(bus_if.valid), 0);

    // acc must be back at 0: one strobe of 1 yields 3
    drive(0, 0, 1, 1);
    exp_q.push_back(3);
    step();
    drive(0, 0, 0, 0);
    repeat (4) step();
    check("final_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
